cond_exec_unit: RTL

- Execute-stage conditional-execution unit for the pipelined ARM core.
- Evaluates the cond field of the E-stage instruction against a registered NZCV flag file, and gates RegWrite, MemWrite, PCSrc and Branch.
- Updates flags per group (NZ / CV) and holds NUM_BANKS independent flag banks, e.g. user and IRQ context.
- Supports stall, flush, a direct flag write (MSR-style), and optional execute/squash counters.

---
 rtl/cond_exec_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cond_exec_unit.sv
// rtl/cond_exec_unit.sv - E-stage ARM condition check, control gating and banked NZCV flags
// Optional execute/squash counters are built only when COND_PERF_CNT_EN is defined.
module cond_exec_unit #(
  parameter int NUM_BANKS = 2,
  parameter int CNT_W     = 32,
  localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             valid_e,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [31:0]      InstrE,
  input  logic [BW-1:0]    bank_sel,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagWriteE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             PCSrcE,
  input  logic             BranchE,
  input  logic             No_WriteE,
  input  logic             flags_wr_en,
  input  logic [3:0]       flags_wr_data,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             PCSrc,
  output logic             BranchTakenE,
  output logic             CondEx,
  output logic [3:0]       flags_out,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [3:0] banks [NUM_BANKS];
  logic [3:0] f;
  logic [3:0] f_next;
  logic       go;
  logic       fn, fz, fc, fv;
  logic       unused_instr;

  assign unused_instr = ^InstrE[27:0];

  // Out-of-range bank_sel matches no bank, so it reads zero and writes nothing
  always_comb begin
    f = 4'b0000;
    for (int i = 0; i < NUM_BANKS; i++)
      if (bank_sel == BW'(i)) f = banks[i];
  end

  assign {fn, fz, fc, fv} = f;
  assign flags_out = f;

  always_comb begin
    CondEx = 1'b1;
    case (InstrE[31:28])
      4'h0:    CondEx = fz;
      4'h1:    CondEx = ~fz;
      4'h2:    CondEx = fc;
      4'h3:    CondEx = ~fc;
      4'h4:    CondEx = fn;
      4'h5:    CondEx = ~fn;
      4'h6:    CondEx = fv;
      4'h7:    CondEx = ~fv;
      4'h8:    CondEx = fc & ~fz;
      4'h9:    CondEx = ~fc | fz;
      4'hA:    CondEx = (fn == fv);
      4'hB:    CondEx = (fn != fv);
      4'hC:    CondEx = ~fz & (fn == fv);
      4'hD:    CondEx = fz | (fn != fv);
      default: CondEx = 1'b1;
    endcase
  end

  assign go           = valid_e & ~flush_e & CondEx;
  assign RegWrite     = go & RegWriteE & ~No_WriteE;
  assign MemWrite     = go & MemWriteE;
  assign PCSrc        = go & PCSrcE;
  assign BranchTakenE = go & BranchE;

  // Direct write wins over ALU groups; go already excludes flushed/invalid slots
  always_comb begin
    f_next = f;
    if (flags_wr_en) begin
      f_next = flags_wr_data;
    end else if (go) begin
      if (FlagWriteE[1]) f_next[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0]) f_next[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) banks[i] <= 4'b0000;
    end else if (!stall_e) begin
      for (int i = 0; i < NUM_BANKS; i++)
        if (bank_sel == BW'(i)) banks[i] <= f_next;
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (valid_e && !flush_e && !stall_e) begin
      if (CondEx) exec_q   <= exec_q + CNT_W'(1);
      else        squash_q <= squash_q + CNT_W'(1);
    end
  end

  assign exec_cnt   = exec_q;
  assign squash_cnt = squash_q;
`else
  assign exec_cnt   = '0;
  assign squash_cnt = '0;
`endif

endmodule
